// File: rtl/io_pkg.sv
// io_pkg: shared definitions for the io_packet_engine slice.
//   io_state_e      - engine FSM state encoding (also exported for debug)
//   HDR_BASE_LSB    - bit offset of the base-address field in the load header
//   hdr_count_lsb() - bit offset of the entry-count field (upper half of the bus word)
//   slice_idx_w()   - width of a slice index for a given DATA_WIDTH/BUS_WIDTH ratio
package io_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RX_HDR  = 3'd1,
        RX_DATA = 3'd2,
        TX_READ = 3'd3,
        TX_WAIT = 3'd4,
        TX_SEND = 3'd5,
        FINISH  = 3'd6
    } io_state_e;

    localparam int HDR_BASE_LSB = 0;

    function automatic int hdr_count_lsb(input int bus_width);
        return bus_width / 2;
    endfunction

    // A ratio of 1 still needs a 1-bit index so the counter has a legal width.
    function automatic int slice_idx_w(input int ratio);
        return (ratio <= 1) ? 1 : $clog2(ratio);
    endfunction

endpackage

// File: rtl/io_packet_engine_if.sv
// io_packet_engine_if: every signal of the engine except CLK/RST.
//   master modport - the engine itself (drives Bus_Out*, Mem_*, status)
//   slave  modport - the surroundings: CPU bus, control and RAM
//   Control : Start, Mode, Send_Base, Send_Count -> engine; Busy, Done <- engine
//   Bus in  : Bus_In, Bus_In_Valid (no ready: the engine takes a word every cycle)
//   Bus out : Bus_Out, Bus_Out_Valid, Bus_Out_Ready, Bus_OE
//   RAM     : Mem_WR_En/Addr/Data (write port), Mem_RD_Addr/Data (read port A, 1-cycle latency)
//   dbg_state: current FSM state, for observation only
//
// Handshake: a Bus_Out word transfers on a rising edge where Bus_Out_Valid and
// Bus_Out_Ready are both high. While Valid is high and Ready is low, Bus_Out
// holds its value and Valid stays high. Valid never depends on Ready.
interface io_packet_engine_if #(
    parameter int BUS_WIDTH     = 32,
    parameter int DATA_WIDTH    = 64,
    parameter int ADDRESS_WIDTH = 13,
    parameter int COUNT_WIDTH   = 13
);
    import io_pkg::*;

    logic                     Start;
    logic                     Mode;
    logic [ADDRESS_WIDTH-1:0] Send_Base;
    logic [COUNT_WIDTH-1:0]   Send_Count;
    logic [BUS_WIDTH-1:0]     Bus_In;
    logic                     Bus_In_Valid;
    logic [BUS_WIDTH-1:0]     Bus_Out;
    logic                     Bus_Out_Valid;
    logic                     Bus_Out_Ready;
    logic                     Bus_OE;
    logic                     Busy;
    logic                     Done;
    logic                     Mem_WR_En;
    logic [ADDRESS_WIDTH-1:0] Mem_WR_Addr;
    logic [DATA_WIDTH-1:0]    Mem_WR_Data;
    logic [ADDRESS_WIDTH-1:0] Mem_RD_Addr;
    logic [DATA_WIDTH-1:0]    Mem_RD_Data;
    io_state_e                dbg_state;

    modport master (
        input  Start, Mode, Send_Base, Send_Count,
        input  Bus_In, Bus_In_Valid, Bus_Out_Ready, Mem_RD_Data,
        output Bus_Out, Bus_Out_Valid, Bus_OE, Busy, Done,
        output Mem_WR_En, Mem_WR_Addr, Mem_WR_Data, Mem_RD_Addr,
        output dbg_state
    );

    modport slave (
        output Start, Mode, Send_Base, Send_Count,
        output Bus_In, Bus_In_Valid, Bus_Out_Ready, Mem_RD_Data,
        input  Bus_Out, Bus_Out_Valid, Bus_OE, Busy, Done,
        input  Mem_WR_En, Mem_WR_Addr, Mem_WR_Data, Mem_RD_Addr,
        input  dbg_state
    );

endinterface

// File: rtl/io_slice_shifter.sv
// io_slice_shifter: one DATA_WIDTH register viewed as RATIO BUS_WIDTH slices.
//   Load mode : shift_in writes in_word into the current slice, LS slice first.
//   Send mode : load copies par_data in; shift_out steps out_word to the next slice.
//   clear     : rewinds the slice index (start of an operation).
//   data      : whole register; out_word: current slice; last: index is at RATIO-1.
// Priority: clear > load > shift_in > shift_out.
module io_slice_shifter
    import io_pkg::*;
#(
    parameter int BUS_WIDTH  = 32,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  load,
    input  logic                  shift_in,
    input  logic                  shift_out,
    input  logic [BUS_WIDTH-1:0]  in_word,
    input  logic [DATA_WIDTH-1:0] par_data,
    output logic [DATA_WIDTH-1:0] data,
    output logic [BUS_WIDTH-1:0]  out_word,
    output logic                  last
);
    localparam int RATIO = DATA_WIDTH / BUS_WIDTH;
    localparam int SW    = slice_idx_w(RATIO);

    logic [SW-1:0] sel;

    assign last = (sel == SW'(RATIO - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data <= '0;
            sel  <= '0;
        end else if (clear) begin
            sel <= '0;
        end else if (load) begin
            data <= par_data;
            sel  <= '0;
        end else if (shift_in) begin
            for (int i = 0; i < RATIO; i++) begin
                if (sel == SW'(i)) begin
                    data[i*BUS_WIDTH +: BUS_WIDTH] <= in_word;
                end
            end
            sel <= last ? '0 : sel + SW'(1);
        end else if (shift_out) begin
            sel <= last ? '0 : sel + SW'(1);
        end
    end

    always_comb begin
        out_word = '0;
        for (int i = 0; i < RATIO; i++) begin
            if (sel == SW'(i)) begin
                out_word = data[i*BUS_WIDTH +: BUS_WIDTH];
            end
        end
    end

endmodule

// File: rtl/io_packet_engine.sv
// io_packet_engine: bidirectional packet engine between the CPU bus and solver RAM.
//   CLK, RST : clock (rising edge), asynchronous active-high reset
//   bus      : io_packet_engine_if.master (control, bus in/out, RAM ports, debug state)
// Load: header word (base, count) then count*RATIO bus words, each full entry
//       written to RAM at base+index. Send: count entries read from Send_Base
//       onward and streamed out LS slice first under valid/ready.
module io_packet_engine
    import io_pkg::*;
#(
    parameter int BUS_WIDTH     = 32,
    parameter int DATA_WIDTH    = 64,
    parameter int ADDRESS_WIDTH = 13,
    parameter int COUNT_WIDTH   = 13
) (
    input  logic CLK,
    input  logic RST,
    io_packet_engine_if.master bus
);
    localparam int CNT_LSB = hdr_count_lsb(BUS_WIDTH);

    io_state_e                state;
    logic [ADDRESS_WIDTH-1:0] addr;   // running RAM address, base + index (wraps)
    logic [COUNT_WIDTH-1:0]   count;
    logic [COUNT_WIDTH-1:0]   idx;    // entries completed so far
    logic                     wr_en;
    logic [ADDRESS_WIDTH-1:0] wr_addr;
    logic                     out_valid;
    logic                     oe;
    logic                     busy;
    logic                     done;

    logic                     accept_in;
    logic                     out_fire;
    logic [COUNT_WIDTH-1:0]   hdr_count;
    logic [DATA_WIDTH-1:0]    sh_data;
    logic [BUS_WIDTH-1:0]     sh_word;
    logic                     sh_last;

    assign hdr_count = bus.Bus_In[CNT_LSB +: COUNT_WIDTH];

    // Once the final entry has been counted, further words are not assembled.
    assign accept_in = (state == RX_DATA) && bus.Bus_In_Valid && (idx != count);
    assign out_fire  = out_valid && bus.Bus_Out_Ready;

    io_slice_shifter #(
        .BUS_WIDTH  (BUS_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_shifter (
        .clk       (CLK),
        .rst       (RST),
        .clear     ((state == IDLE) && bus.Start),
        .load      (state == TX_WAIT),
        .shift_in  (accept_in),
        .shift_out (out_fire),
        .in_word   (bus.Bus_In),
        .par_data  (bus.Mem_RD_Data),
        .data      (sh_data),
        .out_word  (sh_word),
        .last      (sh_last)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            addr      <= '0;
            count     <= '0;
            idx       <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            out_valid <= 1'b0;
            oe        <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.Start) begin
                        idx  <= '0;
                        busy <= 1'b1;
                        if (!bus.Mode) begin
                            state <= RX_HDR;
                        end else begin
                            addr  <= bus.Send_Base;
                            count <= bus.Send_Count;
                            if (bus.Send_Count == '0) begin
                                state <= FINISH;
                                done  <= 1'b1;
                            end else begin
                                state <= TX_READ;
                                oe    <= 1'b1;
                            end
                        end
                    end
                end
                RX_HDR: begin
                    if (bus.Bus_In_Valid) begin
                        addr  <= bus.Bus_In[HDR_BASE_LSB +: ADDRESS_WIDTH];
                        count <= hdr_count;
                        if (hdr_count == '0) begin
                            state <= FINISH;
                            done  <= 1'b1;
                        end else begin
                            state <= RX_DATA;
                        end
                    end
                end
                RX_DATA: begin
                    if (accept_in && sh_last) begin
                        wr_en   <= 1'b1;
                        wr_addr <= addr;
                        addr    <= addr + ADDRESS_WIDTH'(1);
                        idx     <= idx + COUNT_WIDTH'(1);
                    end else if (wr_en && (idx == count)) begin
                        // Leave only after the final write strobe has been presented.
                        state <= FINISH;
                        done  <= 1'b1;
                    end
                end
                TX_READ: begin
                    // addr is already on Mem_RD_Addr; data returns next cycle.
                    state <= TX_WAIT;
                end
                TX_WAIT: begin
                    state     <= TX_SEND;
                    out_valid <= 1'b1;
                end
                TX_SEND: begin
                    if (out_fire && sh_last) begin
                        out_valid <= 1'b0;
                        addr      <= addr + ADDRESS_WIDTH'(1);
                        idx       <= idx + COUNT_WIDTH'(1);
                        if (idx + COUNT_WIDTH'(1) == count) begin
                            state <= FINISH;
                            oe    <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= TX_READ;
                        end
                    end
                end
                FINISH: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    oe    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Bus_Out       = out_valid ? sh_word : '0;
    assign bus.Bus_Out_Valid = out_valid;
    assign bus.Bus_OE        = oe;
    assign bus.Busy          = busy;
    assign bus.Done          = done;
    assign bus.Mem_WR_En     = wr_en;
    assign bus.Mem_WR_Addr   = wr_addr;
    assign bus.Mem_WR_Data   = sh_data;
    assign bus.Mem_RD_Addr   = addr;
    assign bus.dbg_state     = state;

endmodule
